// File: rtl/ahb_ram_bank_if.sv
// ahb_ram_bank_if
//   Strobe-level bus between the AHB-to-RAM bridge and the data RAM bank.
//   master : bridge side, drives address/rden/wren/data/rwtyp/err_clr, receives q/err
//   slave  : RAM side, receives the strobes, drives q/err
interface ahb_ram_bank_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              rden;
    logic              wren;
    logic [DATA_W-1:0] data;
    logic [2:0]        rwtyp;
    logic [DATA_W-1:0] q;
    logic [1:0]        err;
    logic              err_clr;

    modport master (
        output address, rden, wren, data, rwtyp, err_clr,
        input  q, err
    );

    modport slave (
        input  address, rden, wren, data, rwtyp, err_clr,
        output q, err
    );
endinterface

// File: rtl/ahb_ram_bank.sv
// ahb_ram_bank
//   Byte-addressable synchronous data RAM with RISC-V load/store sizing
//   (rwtyp = funct3) and a sticky illegal-access error register.
// Ports
//   clk   : clock, all state on rising edge
//   rstn  : asynchronous active-low reset (clears q and err, not the array)
//   bus   : slave modport -- address/rden/wren/data/rwtyp/err_clr in, q/err out
//           err[0] = misaligned, err[1] = out of range or illegal rwtyp
module ahb_ram_bank #(
    parameter int DEPTH_WORDS = 16384,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic          clk,
    input  logic          rstn,
    ahb_ram_bank_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [3:0][7:0]   r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_q;
    logic [1:0]        r_err;

    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_off;
    logic              w_upper_zero;
    logic              w_idx_ok;
    logic              w_type_bad;
    logic              w_misal;
    logic [1:0]        w_flags;
    logic              w_legal;
    logic [3:0][7:0]   w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_rdata;
    logic [3:0]        w_be;
    logic [3:0][7:0]   w_wdata;

    assign w_idx        = bus.address[IDX_W+1:2];
    assign w_off        = bus.address[1:0];
    assign w_upper_zero = (bus.address[ADDR_W-1:IDX_W+2] == '0);
    // Only matters when DEPTH_WORDS is not a power of two.
    assign w_idx_ok     = ({1'b0, w_idx} < (IDX_W+1)'(DEPTH_WORDS));

    // Alignment is only judged for legal types; a bad type reports err[1] alone.
    always_comb begin
        w_type_bad = 1'b0;
        w_misal    = 1'b0;
        case (bus.rwtyp)
            3'b000, 3'b100: w_misal = 1'b0;
            3'b001, 3'b101: w_misal = w_off[0];
            3'b010:         w_misal = (w_off != 2'b00);
            default:        w_type_bad = 1'b1;
        endcase
    end

    // rwtyp/address are don't-care outside strobe cycles.
    assign w_flags = (bus.rden || bus.wren)
                   ? {w_type_bad | ~w_upper_zero | ~w_idx_ok, w_misal}
                   : 2'b00;
    assign w_legal = (w_flags == 2'b00);

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[w_off];
    assign w_half = w_off[1] ? {w_word[3], w_word[2]} : {w_word[1], w_word[0]};

    always_comb begin
        w_rdata = 32'h0;
        case (bus.rwtyp)
            3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_rdata = {24'h0, w_byte};
            3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
            3'b101:  w_rdata = {16'h0, w_half};
            3'b010:  w_rdata = w_word;
            default: w_rdata = 32'h0;
        endcase
    end

    // Write data is replicated across lanes so the byte enable alone picks the target.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.data[31:0];
        case (bus.rwtyp)
            3'b000, 3'b100: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bus.data[7:0]}};
            end
            3'b001, 3'b101: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.data[15:0]}};
            end
            3'b010: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // The array shares the reset-aware block so a write in a reset cycle is
    // dropped, but its contents are never cleared. The read uses the pre-edge
    // word, giving read-before-write when rden and wren coincide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q   <= '0;
            r_err <= 2'b00;
        end else begin
            if (bus.rden) begin
                r_q <= w_legal ? DATA_W'(w_rdata) : '0;
            end
            if (bus.wren && w_legal) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) begin
                        r_mem[w_idx][i] <= w_wdata[i];
                    end
                end
            end
            r_err <= (r_err & ~{2{bus.err_clr}}) | w_flags;
        end
    end

    assign bus.q   = r_q;
    assign bus.err = r_err;
endmodule

// File: tb/tb_ahb_ram_bank.sv
module tb_ahb_ram_bank;
    localparam int DEPTH_WORDS = 16384;
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    ahb_ram_bank_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_ram_bank #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: flat byte-addressed memory plus expected q/err.
    logic [7:0]  mdl [int];
    logic [31:0] m_q   = 32'h0;
    logic [1:0]  m_err = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
        int n;
        logic [31:0] v;
        n = 1 << t[1:0];
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(a) + i]) << (8 * i));
        if (!t[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // One clock with the given strobes; model updated at the edge, then q/err checked.
    task automatic cycle(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] t, input bit clr);
        logic [1:0] f;
        int n;
        bit bad;
        bus.rden = rd; bus.wren = wr; bus.address = a;
        bus.data = d;  bus.rwtyp = t; bus.err_clr = clr;
        f   = 2'b00;
        bad = (t == 3'd3) || (t == 3'd6) || (t == 3'd7);
        n   = 1 << t[1:0];
        if (rd || wr) begin
            if (bad || a >= LIMIT) f[1] = 1'b1;
            if (!bad && ((a & 32'(n - 1)) != 0)) f[0] = 1'b1;
        end
        @(posedge clk);
        if (!rstn) begin
            m_q = 32'h0; m_err = 2'b00;
        end else begin
            if (rd) m_q = (f == 2'b00) ? model_load(a, t) : 32'h0;
            if (wr && f == 2'b00)
                for (int i = 0; i < n; i++) mdl[int'(a) + i] = 8'(d >> (8 * i));
            m_err = (m_err & ~{2{clr}}) | f;
        end
        #1;
        chk({tag, " q"}, bus.q, m_q);
        chk({tag, " err"}, 32'(bus.err), 32'(m_err));
        bus.rden = 1'b0; bus.wren = 1'b0; bus.err_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  t;
        int r;
        bus.address = '0; bus.rden = 1'b0; bus.wren = 1'b0;
        bus.data = '0; bus.rwtyp = 3'd0; bus.err_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset q", bus.q, 32'h0);
        chk("reset err", 32'(bus.err), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Word store / load
        cycle("sw 10", 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
        cycle("lw 10", 1, 0, 32'h10, 32'h0, 3'b010, 0);
        chk("lw 10 const", bus.q, 32'hDEADBEEF);
        cycle("idle hold", 0, 0, 32'h0, 32'h0, 3'b111, 0);
        chk("q held", bus.q, 32'hDEADBEEF);

        // Byte store into top lane, signed/unsigned loads
        cycle("sb 13", 0, 1, 32'h13, 32'h80, 3'b000, 0);
        cycle("lb 13", 1, 0, 32'h13, 32'h0, 3'b000, 0);
        chk("lb 13 const", bus.q, 32'hFFFFFF80);
        cycle("lbu 13", 1, 0, 32'h13, 32'h0, 3'b100, 0);
        chk("lbu 13 const", bus.q, 32'h00000080);
        cycle("lw 10b", 1, 0, 32'h10, 32'h0, 3'b010, 0);
        chk("lw 10b const", bus.q, 32'h80ADBEEF);

        // Half store into upper half
        cycle("sw 20", 0, 1, 32'h20, 32'h12345678, 3'b010, 0);
        cycle("sh 22", 0, 1, 32'h22, 32'h8001, 3'b001, 0);
        cycle("lh 22", 1, 0, 32'h22, 32'h0, 3'b001, 0);
        chk("lh 22 const", bus.q, 32'hFFFF8001);
        cycle("lhu 22", 1, 0, 32'h22, 32'h0, 3'b101, 0);
        chk("lhu 22 const", bus.q, 32'h00008001);
        cycle("lw 20", 1, 0, 32'h20, 32'h0, 3'b010, 0);
        chk("lw 20 const", bus.q, 32'h80015678);

        // Misaligned accesses
        cycle("sw 11 mis", 0, 1, 32'h11, 32'hCAFEF00D, 3'b010, 0);
        chk("mis err const", 32'(bus.err), 32'h1);
        cycle("lw 10c", 1, 0, 32'h10, 32'h0, 3'b010, 0);
        chk("lw 10c const", bus.q, 32'h80ADBEEF);
        cycle("lh 11 mis", 1, 0, 32'h11, 32'h0, 3'b001, 0);
        chk("lh 11 q const", bus.q, 32'h0);
        cycle("clr", 0, 0, 32'h0, 32'h0, 3'b000, 1);
        chk("clr err const", 32'(bus.err), 32'h0);

        // Illegal type, out of range, clear vs new flag
        cycle("rd typ3", 1, 0, 32'h10, 32'h0, 3'b011, 0);
        chk("typ3 err const", 32'(bus.err), 32'h2);
        cycle("clr2", 0, 0, 32'h0, 32'h0, 3'b000, 1);
        cycle("lw oor", 1, 0, 32'h10000, 32'h0, 3'b010, 0);
        chk("oor err const", 32'(bus.err), 32'h2);
        cycle("lw hi", 1, 0, 32'h80000010, 32'h0, 3'b010, 0);
        cycle("clr+mis", 1, 0, 32'h12, 32'h0, 3'b010, 1);
        chk("clr+mis const", 32'(bus.err), 32'h1);
        cycle("clr3", 0, 0, 32'h0, 32'h0, 3'b000, 1);
        cycle("idle badtyp", 0, 0, 32'h13, 32'h0, 3'b110, 0);
        cycle("sw oor", 0, 1, 32'h10010, 32'hBAD0BAD0, 3'b010, 0);
        cycle("clr4", 0, 0, 32'h0, 32'h0, 3'b000, 1);
        cycle("lw 10 after oor", 1, 0, 32'h10, 32'h0, 3'b010, 0);

        // Simultaneous read/write: read-before-write
        cycle("sw 40", 0, 1, 32'h40, 32'h11111111, 3'b010, 0);
        cycle("rw 40", 1, 1, 32'h40, 32'h22222222, 3'b010, 0);
        chk("rw 40 const", bus.q, 32'h11111111);
        cycle("lw 40", 1, 0, 32'h40, 32'h0, 3'b010, 0);
        chk("lw 40 const", bus.q, 32'h22222222);

        // Randomized phase over a pre-initialised window, with illegal mixes
        for (int i = 0; i < 16; i++)
            cycle("init", 0, 1, 32'h100 + 32'(4 * i), $urandom, 3'b010, 0);
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'h100 + 32'($urandom_range(0, 63));
            else if (r == 8) a = 32'h10000 + 32'($urandom_range(0, 255));
            else             a = $urandom | 32'h00010000;
            t = 3'($urandom_range(0, 7));
            cycle("rand", 1'($urandom), 1'($urandom), a, $urandom, t, ($urandom_range(0, 7) == 0));
        end
        cycle("clr5", 0, 0, 32'h0, 32'h0, 3'b000, 1);

        // Mid-stream asynchronous reset; array must survive, reset-cycle write dropped
        cycle("sw 41 mis", 0, 1, 32'h41, 32'h0, 3'b010, 0);
        #2;
        rstn = 1'b0;
        #1;
        m_q = 32'h0; m_err = 2'b00;
        chk("async rst q", bus.q, 32'h0);
        chk("async rst err", 32'(bus.err), 32'h0);
        cycle("sw in rst", 0, 1, 32'h40, 32'h33333333, 3'b010, 0);
        @(negedge clk);
        rstn = 1'b1;
        cycle("lw 40 post", 1, 0, 32'h40, 32'h0, 3'b010, 0);
        chk("lw 40 post const", bus.q, 32'h22222222);
        cycle("lw 10 post", 1, 0, 32'h10, 32'h0, 3'b010, 0);
        chk("lw 10 post const", bus.q, 32'h80ADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
